ovl_window_checker: RTL and testbench
=====================================

Name: ovl_window_checker

Overview:
- Clocked assertion checker for "test_expr must hold throughout a window".
- A window opens on `start_event` and closes on `end_event`. `test_expr` must be TRUE on every sampled cycle strictly after the opening cycle, up to and including the closing cycle.
- Bound into RTL or testbenches alongside the library's clock generator (`ivl_uvm_ovl_clk_gen`, which is not part of this block).
- Reports violations on a registered `fire` vector, a window-state flag and a saturating violation counter.

Parameters:
- SEVERITY_LEVEL, 1, 0 = info, 1 = error, 2 = fatal. Controls the simulation-only message text; a fatal severity calls $finish after the message. No effect on RTL outputs.
- PROPERTY_TYPE, 0, 0 = assert, 1 = assume, 2 = ignore. Ignore forces `fire[1:0]` to 0.
- CNT_W, 16, width of `viol_count` (and of `win_count` when the optional feature is compiled in).
- X_CHECK, 1, 1 enables the simulation-only X/Z detection on `fire[1]`.

Ports:
- clock  in  1  sampling clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = checking active.
- test_expr  in  1  expression that must be TRUE inside the window.
- start_event  in  1  window-open request, level-sampled.
- end_event  in  1  window-close request, level-sampled.
- fire  out  3  bit0 = assertion violation, bit1 = X/Z detected, bit2 = window completed (cover).
- window_open  out  1  registered window state.
- viol_count  out  CNT_W  saturating count of `fire[0]` pulses.

Behaviour:
- Reset (`reset` = 0, asynchronous): `window_open` = 0, `fire` = 3'b000, `viol_count` = 0. Inputs are ignored while in reset.
- State update at each posedge, independent of `enable`:
  - Closed and `start_event` = 1: open next cycle. A simultaneous `end_event` is ignored.
  - Open and `end_event` = 1: close next cycle. A simultaneous `start_event` is ignored; reopening needs `start_event` in a later cycle.
  - Otherwise `window_open` holds its value.
- Checked cycle: `window_open` = 1 AND `enable` = 1. This includes the cycle in which `end_event` = 1; the cycle where `start_event` is sampled is not checked.
- Violation: checked cycle with `test_expr` = 0.
  - `fire[0]` = 1 for exactly one cycle, on the posedge following the sampled violation (latency 1).
  - Each violating cycle produces its own pulse, so consecutive violations give consecutive pulses.
- `viol_count` increments on each `fire[0]` pulse and saturates at all-ones.
- `fire[1]`: with X_CHECK = 1, a one-cycle registered pulse when `start_event` or `end_event` is X/Z, or when `test_expr` is X/Z in a checked cycle. Simulation-only; synthesizes to 0.
- `enable` = 0: no `fire[0]` or `fire[1]` pulses and no counter increments; window tracking continues.
- Reset asserted mid-window: immediately closes the window and clears all outputs.
- Simulation message (`$display` with instance path, time, severity) on each violation unless PROPERTY_TYPE = 2. Excluded from synthesis.

Optional Feature:
- Macro: OVL_WINDOW_COVER_EN.
- Defined: `fire[2]` pulses for one cycle on the posedge after a window closes with no violation during that window. A CNT_W-bit saturating output `win_count` (reset 0) increments on each such pulse.
- Undefined: `fire[2]` is tied 0 and the `win_count` port and its logic are absent.

Test Plan:
- Reset held 5 clocks with all inputs 0 -> `fire` = 0, `window_open` = 0, `viol_count` = 0 throughout.
- `start_event` pulse (1 cycle), `test_expr` = 1 for 5 cycles, `end_event` pulse with `test_expr` = 1, then `test_expr` = 0; repeat twice -> `fire[0]` never set, `window_open` high from the cycle after start through the end cycle, `fire[2]` 2 pulses and `win_count` = 2 with the COVER_EN macro.
- Window open, `test_expr` = 0 for 2 checked cycles -> `fire[0]` high for 2 consecutive cycles, each one cycle after its violation; `viol_count` = 2.
- Window open, `enable` = 0 while `test_expr` = 0 -> no fire; later `end_event` still closes the window.
- `start_event` and `end_event` = 1 together while closed -> window opens; held together while open -> window closes and stays closed the next cycle.
- Reset driven low mid-window with `test_expr` = 0 -> `window_open`, `fire` and `viol_count` cleared immediately, with no fire after release.

Source files
------------

// File: rtl/ovl_window_checker.sv
// ovl_window_checker
//   Clocked checker for "test_expr must hold throughout a window".
//   A window opens on start_event and closes on end_event. test_expr must be
//   TRUE on every cycle after the opening cycle, up to and including the
//   closing cycle, whenever enable = 1.
//
// Parameters
//   SEVERITY_LEVEL  0 info, 1 error, 2 fatal (simulation message only)
//   PROPERTY_TYPE   0 assert, 1 assume, 2 ignore (ignore forces fire[1:0] = 0)
//   CNT_W           width of viol_count (and win_count)
//   X_CHECK         1 enables simulation-only X/Z detection on fire[1]
//
// Ports
//   clock        sampling clock, rising edge
//   reset        asynchronous, active-low reset
//   enable       1 = checking active (window tracking always runs)
//   test_expr    expression that must be TRUE inside the window
//   start_event  window-open request, level-sampled
//   end_event    window-close request, level-sampled
//   fire[2:0]    bit0 violation, bit1 X/Z seen, bit2 clean window completed
//   window_open  registered window state
//   viol_count   saturating count of fire[0] pulses
//   win_count    saturating count of fire[2] pulses (OVL_WINDOW_COVER_EN only)
//
// Optional feature macro: OVL_WINDOW_COVER_EN enables fire[2] and win_count.
module ovl_window_checker #(
  parameter int SEVERITY_LEVEL = 1,
  parameter int PROPERTY_TYPE  = 0,
  parameter int CNT_W          = 16,
  parameter bit X_CHECK        = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             test_expr,
  input  logic             start_event,
  input  logic             end_event,
  output logic [2:0]       fire,
  output logic             window_open,
  output logic [CNT_W-1:0] viol_count
`ifdef OVL_WINDOW_COVER_EN
  ,
  output logic [CNT_W-1:0] win_count
`endif
);

  typedef enum logic {WIN_CLOSED = 1'b0, WIN_OPEN = 1'b1} win_state_e;

  win_state_e state, state_next;

  logic checked;
  logic viol;
  logic viol_report;
  logic x_seen;

  // A cycle is checked only while the window was already open before it, so
  // the cycle that samples start_event is excluded and the end cycle counts.
  assign checked     = (state == WIN_OPEN) && enable;
  assign viol        = checked && !test_expr;
  assign viol_report = viol && (PROPERTY_TYPE != 2);

`ifdef SYNTHESIS
  assign x_seen = 1'b0;
`else
  assign x_seen = X_CHECK && enable && (PROPERTY_TYPE != 2) &&
                  ($isunknown(start_event) || $isunknown(end_event) ||
                   (checked && $isunknown(test_expr)));
`endif

  // Window FSM: a simultaneous end while closed, or start while open, is
  // ignored, so reopening needs a fresh start_event in a later cycle.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      WIN_CLOSED: if (start_event) state_next = WIN_OPEN;
      WIN_OPEN:   if (end_event)   state_next = WIN_CLOSED;
      default:    state_next = WIN_CLOSED;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= WIN_CLOSED;
      fire[1:0]  <= 2'b00;
      viol_count <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values together.
      state     <= state_next;
      fire[1:0] <= 2'b00;
      if (viol_report) begin
        fire[0] <= 1'b1;
        if (viol_count != {CNT_W{1'b1}}) viol_count <= viol_count + CNT_W'(1);
      end
      if (x_seen) fire[1] <= 1'b1;
    end
  end

  assign window_open = (state == WIN_OPEN);

`ifdef OVL_WINDOW_COVER_EN
  // clean tracks whether the current window has seen a violation so far;
  // the end cycle's own sample is folded in when the window closes.
  logic clean;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clean     <= 1'b0;
      fire[2]   <= 1'b0;
      win_count <= '0;
    end else begin
      fire[2] <= 1'b0;
      if (state == WIN_CLOSED) begin
        if (start_event) clean <= 1'b1;
      end else begin
        if (viol) clean <= 1'b0;
        if (end_event && clean && !viol) begin
          fire[2] <= 1'b1;
          if (win_count != {CNT_W{1'b1}}) win_count <= win_count + CNT_W'(1);
        end
      end
    end
  end
`else
  assign fire[2] = 1'b0;
`endif

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset && viol_report) begin
      case (SEVERITY_LEVEL)
        0:       $display("%m @%0t: OVL_INFO window: test_expr low inside window", $time);
        1:       $display("%m @%0t: OVL_ERROR window: test_expr low inside window", $time);
        default: $display("%m @%0t: OVL_FATAL window: test_expr low inside window", $time);
      endcase
      if (SEVERITY_LEVEL == 2) $finish;
    end
  end
`endif

endmodule

// File: tb/tb_ovl_window_checker.sv
// Directed bench for ovl_window_checker. A main instance (defaults), a
// narrow-counter instance (CNT_W = 2) for saturation and an ignore-mode
// instance (PROPERTY_TYPE = 2) all watch the same stimulus.
module tb_ovl_window_checker;

  logic clock = 1'b0;
  logic reset;
  logic enable, test_expr, start_event, end_event;

  logic [2:0]  fire, fire_sat, fire_ign;
  logic        win, win_sat, win_ign;
  logic [15:0] vcnt, vcnt_ign;
  logic [1:0]  vcnt_sat;
`ifdef OVL_WINDOW_COVER_EN
  logic [15:0] wcnt, wcnt_ign;
  logic [1:0]  wcnt_sat;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ovl_window_checker dut (
    .clock(clock), .reset(reset), .enable(enable), .test_expr(test_expr),
    .start_event(start_event), .end_event(end_event),
    .fire(fire), .window_open(win), .viol_count(vcnt)
`ifdef OVL_WINDOW_COVER_EN
    , .win_count(wcnt)
`endif
  );

  ovl_window_checker #(.CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .enable(enable), .test_expr(test_expr),
    .start_event(start_event), .end_event(end_event),
    .fire(fire_sat), .window_open(win_sat), .viol_count(vcnt_sat)
`ifdef OVL_WINDOW_COVER_EN
    , .win_count(wcnt_sat)
`endif
  );

  ovl_window_checker #(.PROPERTY_TYPE(2)) dut_ign (
    .clock(clock), .reset(reset), .enable(enable), .test_expr(test_expr),
    .start_event(start_event), .end_event(end_event),
    .fire(fire_ign), .window_open(win_ign), .viol_count(vcnt_ign)
`ifdef OVL_WINDOW_COVER_EN
    , .win_count(wcnt_ign)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Compare the main instance's window flag, fire bits 1:0 and violation count.
  task automatic expect_main(input string tag, input logic w, input logic [1:0] f, input int vc);
    check({tag, ".win"},  32'(win),       32'(w));
    check({tag, ".fire"}, 32'(fire[1:0]), 32'(f));
    check({tag, ".vcnt"}, 32'(vcnt),      32'(vc));
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; test_expr = 1'b0;
    start_event = 1'b0; end_event = 1'b0;

    // Reset held for 5 clocks with all inputs low.
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_main("reset", 1'b0, 2'b00, 0);
      check("reset.fire2", 32'(fire[2]), 32'd0);
    end
    reset = 1'b1; enable = 1'b1; test_expr = 1'b1;

    // Two clean windows.
    for (int w = 0; w < 2; w++) begin
      start_event = 1'b1;
      tick();
      expect_main("clean.open", 1'b1, 2'b00, 0);
      start_event = 1'b0;
      for (int c = 0; c < 5; c++) begin
        tick();
        expect_main("clean.hold", 1'b1, 2'b00, 0);
      end
      end_event = 1'b1;
      tick();
      expect_main("clean.close", 1'b0, 2'b00, 0);
`ifdef OVL_WINDOW_COVER_EN
      check("clean.cover", 32'(fire[2]), 32'd1);
      check("clean.wcnt",  32'(wcnt),    32'(w + 1));
`endif
      end_event = 1'b0; test_expr = 1'b0;
      tick();
      expect_main("clean.after", 1'b0, 2'b00, 0);
      test_expr = 1'b1;
    end

    // Two consecutive violations, each reported one cycle later.
    start_event = 1'b1;
    tick();
    start_event = 1'b0; test_expr = 1'b0;
    tick();
    expect_main("viol.1", 1'b1, 2'b01, 1);
    check("viol.ign_fire", 32'(fire_ign), 32'd0);
    tick();
    expect_main("viol.2", 1'b1, 2'b01, 2);
    check("viol.sat_cnt", 32'(vcnt_sat), 32'd2);
    test_expr = 1'b1;
    tick();
    expect_main("viol.clear", 1'b1, 2'b00, 2);
    check("viol.ign_cnt", 32'(vcnt_ign), 32'd0);
    end_event = 1'b1;
    tick();
    expect_main("viol.close", 1'b0, 2'b00, 2);
    check("viol.nocover", 32'(fire[2]), 32'd0);
    end_event = 1'b0;

    // enable low suppresses checking but window tracking continues.
    start_event = 1'b1;
    tick();
    start_event = 1'b0; enable = 1'b0; test_expr = 1'b0;
    tick();
    expect_main("dis.1", 1'b1, 2'b00, 2);
    tick();
    expect_main("dis.2", 1'b1, 2'b00, 2);
    end_event = 1'b1;
    tick();
    expect_main("dis.close", 1'b0, 2'b00, 2);
    end_event = 1'b0; enable = 1'b1; test_expr = 1'b1;
    tick();

    // Simultaneous start and end: open from closed, then close from open.
    start_event = 1'b1; end_event = 1'b1;
    tick();
    expect_main("both.open", 1'b1, 2'b00, 2);
    tick();
    expect_main("both.close", 1'b0, 2'b00, 2);
    start_event = 1'b0; end_event = 1'b0;
    tick();
    expect_main("both.stay", 1'b0, 2'b00, 2);

    // Three more violations: the 2-bit counter saturates at 3.
    start_event = 1'b1;
    tick();
    start_event = 1'b0; test_expr = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    expect_main("sat.main", 1'b1, 2'b01, 5);
    check("sat.cnt", 32'(vcnt_sat), 32'd3);

    // Reset asserted mid-window clears everything immediately.
    tick();
    expect_main("rst.pre", 1'b1, 2'b01, 6);
    check("rst.sat_hold", 32'(vcnt_sat), 32'd3);
    reset = 1'b0;
    #1;
    expect_main("rst.now", 1'b0, 2'b00, 0);
    check("rst.sat_cnt", 32'(vcnt_sat), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    expect_main("rst.after1", 1'b0, 2'b00, 0);
    tick();
    expect_main("rst.after2", 1'b0, 2'b00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
